// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tetris_pkg
//  Description : Shared definitions for the Tetris playfield engine:
//                FSM state encoding, common 4x4 shape constants and the
//                clockwise rotation of a 4x4 shape (bit index y*4+x).
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [15:0] C_SHAPE_NONE = 16'h0000;
    localparam logic [15:0] C_SHAPE_O    = 16'h0660;
    localparam logic [15:0] C_SHAPE_I_H  = 16'h00F0;
    localparam logic [15:0] C_SHAPE_I_V  = 16'h4444;

    // Clockwise rotation: result cell (x,y) takes source cell (y, 3-x),
    // i.e. result bit y*4+x = source bit (3-x)*4+y. Listed MSB first.
    function automatic logic [15:0] rotate_cw(input logic [15:0] s);
        return {s[3], s[7], s[11], s[15],
                s[2], s[6], s[10], s[14],
                s[1], s[5], s[9],  s[13],
                s[0], s[4], s[8],  s[12]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_fit_check.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_fit_check
//  Description : Combinational placement test of a 4x4 shape at signed
//                position (x,y) against the locked grid. A set shape cell
//                fails if it falls outside the field or on a set grid cell;
//                clear shape cells never fail.
//  Ports       : grid  - locked grid, bit index y*FIELD_W+x
//                shape - 4x4 shape, bit index y*4+x
//                x, y  - signed top-left corner of the shape
//                fits  - 1 when no set shape cell collides
//  Revision    : 1.0 - initial release
// ============================================================================
module tetris_fit_check #(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20,
    parameter int COORD_W = 7
) (
    input  logic [FIELD_W*FIELD_H-1:0] grid,
    input  logic [15:0]                shape,
    input  logic signed [COORD_W-1:0]  x,
    input  logic signed [COORD_W-1:0]  y,
    output logic                       fits
);

    localparam int C_IDX_W = $clog2(FIELD_W * FIELD_H);
    localparam logic signed [COORD_W-1:0] C_W = COORD_W'(FIELD_W);
    localparam logic signed [COORD_W-1:0] C_H = COORD_W'(FIELD_H);

    logic [15:0] w_hit;

    for (genvar k = 0; k < 16; k++) begin : g_cell
        localparam logic signed [COORD_W-1:0] C_DX = COORD_W'(k % 4);
        localparam logic signed [COORD_W-1:0] C_DY = COORD_W'(k / 4);
        logic signed [COORD_W-1:0] w_cx;
        logic signed [COORD_W-1:0] w_cy;
        logic                      w_in;
        logic [C_IDX_W-1:0]        w_idx;

        assign w_cx  = x + C_DX;
        assign w_cy  = y + C_DY;
        assign w_in  = !w_cx[COORD_W-1] && (w_cx < C_W) &&
                       !w_cy[COORD_W-1] && (w_cy < C_H);
        // Index is only meaningful when w_in is set.
        assign w_idx = C_IDX_W'(w_cy) * C_IDX_W'(FIELD_W) + C_IDX_W'(w_cx);
        assign w_hit[k] = shape[k] & (~w_in | grid[w_idx]);
    end

    assign fits = ~|w_hit;

endmodule
`default_nettype wire

// File: rtl/tetris_playfield.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_playfield
//  Description : Playfield engine. Holds the locked grid and the active 4x4
//                piece, applies rotate/left/right/down with collision tests,
//                locks the piece on bottom contact, then scans rows bottom-up
//                one per cycle removing full rows and counting them.
//  Ports       : clock, reset (async, active-high)
//                left/right/down/rotate - 1-cycle command pulses
//                piece_valid/piece_shape/piece_ready - next-piece handshake
//                field_out  - grid OR active piece, bit index y*FIELD_W+x
//                score      - saturating cleared-row count
//                line_pulse - one cycle per cleared row
//                game_over  - sticky until reset
//  Revision    : 1.0 - initial release
// ============================================================================
module tetris_playfield
    import tetris_pkg::*;
#(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20,
    parameter int SPAWN_X = 8,
    parameter int SCORE_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       left,
    input  logic                       right,
    input  logic                       down,
    input  logic                       rotate,
    input  logic                       piece_valid,
    input  logic [15:0]                piece_shape,
    output logic                       piece_ready,
    output logic [FIELD_W*FIELD_H-1:0] field_out,
    output logic [SCORE_W-1:0]         score,
    output logic                       line_pulse,
    output logic                       game_over
);

    localparam int C_CW    = $clog2((FIELD_W > FIELD_H) ? FIELD_W : FIELD_H) + 2;
    localparam int C_IDX_W = $clog2(FIELD_W * FIELD_H);
    localparam int C_RW    = $clog2(FIELD_H);
    localparam int C_N     = FIELD_W * FIELD_H;
    localparam logic signed [C_CW-1:0] C_SPAWN_X = C_CW'(SPAWN_X);
    localparam logic signed [C_CW-1:0] C_ONE     = C_CW'(1);
    localparam logic signed [C_CW-1:0] C_W       = C_CW'(FIELD_W);
    localparam logic signed [C_CW-1:0] C_H       = C_CW'(FIELD_H);
    localparam logic [C_RW-1:0]        C_LAST    = C_RW'(FIELD_H - 1);

    state_t                   r_state;
    logic [C_N-1:0]           r_grid;
    logic [15:0]              r_piece;
    logic signed [C_CW-1:0]   r_px;
    logic signed [C_CW-1:0]   r_py;
    logic [C_RW-1:0]          r_row;
    logic [SCORE_W-1:0]       r_score;
    logic                     r_line_pulse;
    logic                     r_game_over;

    logic [15:0]              w_rot_shape;
    logic                     w_rot_fits;
    logic                     w_lr_fits;
    logic                     w_down_fits;
    logic [15:0]              w_lr_shape;
    logic signed [C_CW-1:0]   w_lr_x;
    logic signed [C_CW-1:0]   w_lr_y;
    logic signed [C_CW-1:0]   w_down_y;
    logic [C_N-1:0]           w_overlay;
    logic [C_N-1:0]           w_shifted;
    logic [FIELD_H-1:0]       w_full;
    logic                     w_row_full;
    logic [15:0]              w_cell_in;
    logic [C_IDX_W-1:0]       w_cell_idx [16];

    assign w_rot_shape = rotate_cw(r_piece);
    assign w_down_y    = r_py + C_ONE;

    // The sideways checker doubles as the spawn checker: it is idle in SPAWN.
    assign w_lr_shape = (r_state == ST_SPAWN) ? piece_shape : r_piece;
    assign w_lr_x     = (r_state == ST_SPAWN) ? C_SPAWN_X :
                        (left ? (r_px - C_ONE) : (r_px + C_ONE));
    assign w_lr_y     = (r_state == ST_SPAWN) ? '0 : r_py;

    tetris_fit_check #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .COORD_W(C_CW)) u_fit_rot (
        .grid(r_grid), .shape(w_rot_shape), .x(r_px), .y(r_py), .fits(w_rot_fits)
    );
    tetris_fit_check #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .COORD_W(C_CW)) u_fit_lr (
        .grid(r_grid), .shape(w_lr_shape), .x(w_lr_x), .y(w_lr_y), .fits(w_lr_fits)
    );
    tetris_fit_check #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .COORD_W(C_CW)) u_fit_down (
        .grid(r_grid), .shape(r_piece), .x(r_px), .y(w_down_y), .fits(w_down_fits)
    );

    // Active piece projected onto the grid (used for display and for locking).
    for (genvar k = 0; k < 16; k++) begin : g_cell
        localparam logic signed [C_CW-1:0] C_DX = C_CW'(k % 4);
        localparam logic signed [C_CW-1:0] C_DY = C_CW'(k / 4);
        logic signed [C_CW-1:0] w_cx;
        logic signed [C_CW-1:0] w_cy;

        assign w_cx          = r_px + C_DX;
        assign w_cy          = r_py + C_DY;
        assign w_cell_in[k]  = !w_cx[C_CW-1] && (w_cx < C_W) && !w_cy[C_CW-1] && (w_cy < C_H);
        assign w_cell_idx[k] = C_IDX_W'(w_cy) * C_IDX_W'(FIELD_W) + C_IDX_W'(w_cx);
    end

    always_comb begin
        w_overlay = '0;
        for (int k = 0; k < 16; k++) begin
            if (r_piece[k] && w_cell_in[k]) begin
                w_overlay[w_cell_idx[k]] = 1'b1;
            end
        end
    end

    // Row-full flags and the grid as it would look with row r_row removed.
    for (genvar y = 0; y < FIELD_H; y++) begin : g_row
        assign w_full[y] = &r_grid[y*FIELD_W +: FIELD_W];
        if (y == 0) begin : g_top
            assign w_shifted[FIELD_W-1:0] = '0;
        end else begin : g_body
            assign w_shifted[y*FIELD_W +: FIELD_W] = (r_row >= C_RW'(y)) ?
                r_grid[(y-1)*FIELD_W +: FIELD_W] : r_grid[y*FIELD_W +: FIELD_W];
        end
    end

    assign w_row_full = w_full[r_row];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SPAWN;
            r_grid       <= '0;
            r_piece      <= C_SHAPE_NONE;
            r_px         <= C_SPAWN_X;
            r_py         <= '0;
            r_row        <= '0;
            r_score      <= '0;
            r_line_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_line_pulse <= 1'b0;
            case (r_state)
                ST_SPAWN: begin
                    if (piece_valid) begin
                        r_piece <= piece_shape;
                        r_px    <= C_SPAWN_X;
                        r_py    <= '0;
                        if (w_lr_fits) begin
                            r_state <= ST_PLAY;
                        end else begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    // One command per cycle; lower-priority ones are dropped.
                    if (rotate) begin
                        if (w_rot_fits) r_piece <= w_rot_shape;
                    end else if (left) begin
                        if (w_lr_fits) r_px <= r_px - C_ONE;
                    end else if (right) begin
                        if (w_lr_fits) r_px <= r_px + C_ONE;
                    end else if (down) begin
                        if (w_down_fits) begin
                            r_py <= w_down_y;
                        end else begin
                            r_grid  <= r_grid | w_overlay;
                            r_row   <= C_LAST;
                            r_state <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    // A removed row pulls new content into r_row, so the
                    // same row is tested again before moving up.
                    if (w_row_full) begin
                        r_grid       <= w_shifted;
                        r_line_pulse <= 1'b1;
                        if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + SCORE_W'(1);
                    end else if (r_row == '0) begin
                        r_state <= ST_SPAWN;
                    end else begin
                        r_row <= r_row - C_RW'(1);
                    end
                end
                ST_OVER: begin
                    r_game_over <= 1'b1;
                end
                default: begin
                    r_state <= ST_SPAWN;
                end
            endcase
        end
    end

    assign piece_ready = (r_state == ST_SPAWN);
    assign field_out   = (r_state == ST_PLAY) ? (r_grid | w_overlay) : r_grid;
    assign score       = r_score;
    assign line_pulse  = r_line_pulse;
    assign game_over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_tetris_playfield.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetris_playfield
//  Description : Self-checking bench for tetris_playfield on a small field.
//                A reference model of the playfield rules predicts every
//                cycle's outputs into a queue; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_playfield;

    localparam int W  = 6;
    localparam int H  = 8;
    localparam int SX = 1;
    localparam int SW = 2;
    localparam int SCORE_MAX = (1 << SW) - 1;

    localparam int M_SPAWN = 0;
    localparam int M_PLAY  = 1;
    localparam int M_CLEAR = 2;
    localparam int M_OVER  = 3;

    localparam logic [15:0] SH_O  = 16'h0660;
    localparam logic [15:0] SH_IH = 16'h00F0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          left = 1'b0, right = 1'b0, down = 1'b0, rotate = 1'b0;
    logic          piece_valid = 1'b0;
    logic [15:0]   piece_shape = 16'h0;
    logic          piece_ready;
    logic [W*H-1:0] field_out;
    logic [SW-1:0] score;
    logic          line_pulse;
    logic          game_over;

    tetris_playfield #(.FIELD_W(W), .FIELD_H(H), .SPAWN_X(SX), .SCORE_W(SW)) dut (
        .clock(clock), .reset(reset), .left(left), .right(right), .down(down),
        .rotate(rotate), .piece_valid(piece_valid), .piece_shape(piece_shape),
        .piece_ready(piece_ready), .field_out(field_out), .score(score),
        .line_pulse(line_pulse), .game_over(game_over)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W*H-1:0] field;
        logic [SW-1:0]  score;
        logic           line;
        logic           over;
        logic           ready;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // ---------------- reference model ----------------
    bit          mg[H][W];
    logic [15:0] mp;
    int          mpx, mpy, mst, mrow, mscore;
    bit          mline;

    function automatic bit fits(logic [15:0] s, int x, int y);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                if (s[j*4+i]) begin
                    int gx, gy;
                    gx = x + i;
                    gy = y + j;
                    if (gx < 0 || gx >= W || gy < 0 || gy >= H) return 1'b0;
                    if (mg[gy][gx]) return 1'b0;
                end
        return 1'b1;
    endfunction

    function automatic logic [15:0] rot(logic [15:0] s);
        logic [15:0] r;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                r[y*4+x] = s[(3-x)*4+y];
        return r;
    endfunction

    function automatic void model_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mg[y][x] = 1'b0;
        mp = 16'h0; mpx = SX; mpy = 0; mst = M_SPAWN; mrow = 0; mscore = 0; mline = 1'b0;
    endfunction

    function automatic void model_step(bit l, bit r, bit d, bit rt, bit v, logic [15:0] s);
        mline = 1'b0;
        case (mst)
            M_SPAWN: if (v) begin
                mp = s; mpx = SX; mpy = 0;
                mst = fits(s, SX, 0) ? M_PLAY : M_OVER;
            end
            M_PLAY: begin
                if (rt) begin
                    if (fits(rot(mp), mpx, mpy)) mp = rot(mp);
                end else if (l) begin
                    if (fits(mp, mpx - 1, mpy)) mpx--;
                end else if (r) begin
                    if (fits(mp, mpx + 1, mpy)) mpx++;
                end else if (d) begin
                    if (fits(mp, mpx, mpy + 1)) mpy++;
                    else begin
                        for (int j = 0; j < 4; j++)
                            for (int i = 0; i < 4; i++)
                                if (mp[j*4+i]) mg[mpy+j][mpx+i] = 1'b1;
                        mst = M_CLEAR;
                        mrow = H - 1;
                    end
                end
            end
            M_CLEAR: begin
                bit full;
                full = 1'b1;
                for (int x = 0; x < W; x++) if (!mg[mrow][x]) full = 1'b0;
                if (full) begin
                    for (int y = mrow; y > 0; y--)
                        for (int x = 0; x < W; x++) mg[y][x] = mg[y-1][x];
                    for (int x = 0; x < W; x++) mg[0][x] = 1'b0;
                    mline = 1'b1;
                    if (mscore < SCORE_MAX) mscore++;
                end else if (mrow == 0) mst = M_SPAWN;
                else mrow--;
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t expected();
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                bit p;
                p = 1'b0;
                if (mst == M_PLAY && x - mpx >= 0 && x - mpx < 4 && y - mpy >= 0 && y - mpy < 4)
                    p = mp[(y-mpy)*4 + (x-mpx)];
                e.field[y*W+x] = mg[y][x] | p;
            end
        e.score = mscore[SW-1:0];
        e.line  = mline;
        e.over  = (mst == M_OVER);
        e.ready = (mst == M_SPAWN);
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (line_pulse) pulses++;
            if (exp_q.size() > 0) begin
                exp_t e, g;
                e = exp_q.pop_front();
                g = '{field: field_out, score: score, line: line_pulse, over: game_over, ready: piece_ready};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t field got %h exp %h score got %0d exp %0d line %b/%b over %b/%b ready %b/%b",
                             $time, g.field, e.field, g.score, e.score, g.line, e.line,
                             g.over, e.over, g.ready, e.ready);
                end
            end
        end
    end

    // ---------------- driver helpers (all called at a falling edge) ----------------
    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step(bit l, bit r, bit d, bit rt, bit v, logic [15:0] s);
        left = l; right = r; down = d; rotate = rt; piece_valid = v; piece_shape = s;
        model_step(l, r, d, rt, v, s);
        exp_q.push_back(expected());
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        left = 1'b0; right = 1'b0; down = 1'b0; rotate = 1'b0; piece_valid = 1'b0;
        #1;
        chk("async_reset_outputs", {field_out, score, line_pulse, game_over, piece_ready},
            {{(W*H){1'b0}}, {SW{1'b0}}, 1'b0, 1'b0, 1'b1});
        model_reset();
        exp_q.push_back(expected());
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drop();
        for (int i = 0; i < 4 * H && mst == M_PLAY; i++) step(0, 0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 3 * H && mst == M_CLEAR; i++) step(0, 0, 0, 0, 0, 16'h0);
        chk("drop_settled", (mst == M_SPAWN || mst == M_OVER), 1);
    endtask

    logic [15:0] shapes [7] = '{16'h0660, 16'h00F0, 16'h0027, 16'h0036, 16'h0063, 16'h0017, 16'h0047};

    initial begin
        int p0;
        model_reset();
        @(negedge clock);
        do_reset();

        // O piece spawn, then push into the left wall
        step(0, 0, 0, 0, 1, SH_O);
        chk("spawn_O_cells", {field_out[W+SX+1], field_out[W+SX+2], field_out[2*W+SX+1], field_out[2*W+SX+2], piece_ready}, 5'b11110);
        repeat (5) step(1, 0, 0, 0, 0, 16'h0);
        chk("left_wall_col0", {field_out[W+0], field_out[W+1], field_out[W+2]}, 3'b110);
        drop();
        do_reset();

        // rotate has priority over left; right wall; rotation into wall refused
        step(0, 0, 0, 0, 1, SH_IH);
        step(1, 0, 0, 1, 0, 16'h0);
        chk("rotate_beats_left", {field_out[3], field_out[W+3], field_out[2*W+3], field_out[3*W+3]}, 4'hF);
        repeat (3) step(0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 0, 16'h0);
        chk("rotate_into_wall", {field_out[5], field_out[W+5], field_out[2*W+5], field_out[3*W+5], field_out[W+4]}, 5'b11110);
        drop();
        do_reset();

        // four line clears, score saturates at 3
        p0 = pulses;
        repeat (2) begin
            step(0, 0, 0, 0, 1, SH_IH); step(1, 0, 0, 0, 0, 16'h0); drop();
            step(0, 0, 0, 0, 1, SH_O);  repeat (2) step(0, 1, 0, 0, 0, 16'h0); drop();
            step(0, 0, 0, 0, 1, SH_IH); step(1, 0, 0, 0, 0, 16'h0); drop();
        end
        chk("score_saturated", score, SCORE_MAX);
        chk("line_pulse_count", pulses - p0, 4);
        do_reset();

        // stack O pieces until spawn collides
        for (int i = 0; i < 6 && mst != M_OVER; i++) begin
            step(0, 0, 0, 0, 1, SH_O);
            drop();
        end
        chk("game_over_set", game_over, 1);
        repeat (10) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                         $urandom_range(0, 1), 1, shapes[$urandom_range(0, 6)]);
        chk("game_over_sticky", {game_over, piece_ready}, 2'b10);
        do_reset();

        // randomized play
        for (int n = 0; n < 3000; n++) begin
            if (mst == M_OVER && $urandom_range(0, 7) == 0) do_reset();
            else if ($urandom_range(0, 499) == 0) do_reset();
            else step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) != 0, shapes[$urandom_range(0, 6)]);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
